// File: rtl/spi_slave_responder.sv
// SPI mode-0 responder oversampled in the clk_i domain: receives MOSI bytes, shifts queued bytes out on MISO.
// Define SPI_SLAVE_TX_FIFO_EN for a 2**TX_FIFO_AW entry TX FIFO; otherwise TX storage is one holding register.
module spi_slave_responder #(
    parameter logic [7:0] IDLE_BYTE  = 8'hFF,
    parameter int         TX_FIFO_AW = 2
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       spi_ss_i,
    input  logic       spi_sck_i,
    input  logic       spi_mosi_i,
    output logic       spi_miso_o,
    output logic       spi_miso_oe_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic [7:0] tx_data_i,
    input  logic       tx_wr_i,
    output logic       tx_ready_o,
    output logic       tx_underrun_o
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t     state;
    logic       ss_meta, ss_sync;
    logic       sck_meta, sck_sync, sck_prev;
    logic       mosi_meta, mosi_sync;
    logic       sck_rise, sck_fall;
    logic [2:0] bitcnt;
    logic [7:0] tx_shift;
    logic [7:0] rx_shift;
    logic       load;
    logic       push;
    logic       store_empty;
    logic [7:0] store_head;
    logic [7:0] load_byte;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ss_meta   <= 1'b1;
            ss_sync   <= 1'b1;
            sck_meta  <= 1'b0;
            sck_sync  <= 1'b0;
            sck_prev  <= 1'b0;
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make each stage take the pre-edge value, giving a real 2-FF chain.
            ss_meta   <= spi_ss_i;
            ss_sync   <= ss_meta;
            sck_meta  <= spi_sck_i;
            sck_sync  <= sck_meta;
            sck_prev  <= sck_sync;
            mosi_meta <= spi_mosi_i;
            mosi_sync <= mosi_meta;
        end
    end

    assign sck_rise  = sck_sync & ~sck_prev;
    assign sck_fall  = ~sck_sync & sck_prev;

    // A TX byte is consumed on select, and at every byte boundary while still selected.
    assign load      = (state == IDLE) ? ~ss_sync
                                       : (~ss_sync & sck_fall & (bitcnt == 3'd0));
    assign push      = tx_wr_i & tx_ready_o;
    assign load_byte = store_empty ? IDLE_BYTE : store_head;

`ifdef SPI_SLAVE_TX_FIFO_EN
    localparam int DEPTH = 1 << TX_FIFO_AW;

    logic [7:0]            mem [DEPTH];
    logic [TX_FIFO_AW-1:0] rd_ptr, wr_ptr;
    logic [TX_FIFO_AW:0]   count;
    logic                  pop;

    assign store_empty = (count == '0);
    assign store_head  = mem[rd_ptr];
    assign pop         = load & ~store_empty;
    // count never exceeds DEPTH, so its MSB alone flags a full FIFO.
    assign tx_ready_o  = ~count[TX_FIFO_AW];

    // NOTE: the data array is not reset; count and the pointers decide which entries are meaningful.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= tx_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + TX_FIFO_AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + TX_FIFO_AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (TX_FIFO_AW + 1)'(1);
                2'b01:   count <= count - (TX_FIFO_AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end
`else
    logic [7:0] hold_data;
    logic       hold_valid;

    assign store_empty = ~hold_valid;
    assign store_head  = hold_data;
    assign tx_ready_o  = ~hold_valid;

    // A write can only land while empty, so a same-cycle load has already taken IDLE_BYTE.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hold_data  <= 8'h00;
            hold_valid <= 1'b0;
        end else if (push) begin
            hold_data  <= tx_data_i;
            hold_valid <= 1'b1;
        end else if (load) begin
            hold_valid <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state         <= IDLE;
            spi_miso_oe_o <= 1'b0;
            bitcnt        <= 3'd0;
            tx_shift      <= 8'h00;
            rx_shift      <= 8'h00;
            rx_data_o     <= 8'h00;
            rx_valid_o    <= 1'b0;
            tx_underrun_o <= 1'b0;
        end else begin
            rx_valid_o    <= 1'b0;
            tx_underrun_o <= 1'b0;
            case (state)
                IDLE: begin
                    spi_miso_oe_o <= 1'b0;
                    bitcnt        <= 3'd0;
                    if (load) begin
                        state         <= ACTIVE;
                        spi_miso_oe_o <= 1'b1;
                        tx_shift      <= load_byte;
                        tx_underrun_o <= store_empty;
                    end
                end
                ACTIVE: begin
                    if (ss_sync) begin
                        // Deselect wins over any same-cycle SCK edge: partial RX and pending TX are dropped.
                        state         <= IDLE;
                        spi_miso_oe_o <= 1'b0;
                        bitcnt        <= 3'd0;
                        rx_shift      <= 8'h00;
                        tx_shift      <= 8'h00;
                    end else if (sck_rise) begin
                        rx_shift <= {rx_shift[6:0], mosi_sync};
                        bitcnt   <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) begin
                            rx_data_o  <= {rx_shift[6:0], mosi_sync};
                            rx_valid_o <= 1'b1;
                        end
                    end else if (sck_fall) begin
                        if (load) begin
                            tx_shift      <= load_byte;
                            tx_underrun_o <= store_empty;
                        end else begin
                            tx_shift <= {tx_shift[6:0], 1'b0};
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign spi_miso_o = spi_miso_oe_o ? tx_shift[7] : 1'b1;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Bench for spi_slave_responder: an SPI master at clk/8 with a queue-based model of TX storage and RX bytes.
// Compile with +define+SPI_SLAVE_TX_FIFO_EN to exercise the FIFO build.
module tb_spi_slave_responder;

`ifdef SPI_SLAVE_TX_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    typedef logic [7:0] byte_q_t[$];

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ss = 1'b1;
    logic       sck = 1'b0;
    logic       mosi = 1'b0;
    logic       tx_wr = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       miso, miso_oe, rx_valid, tx_ready, tx_underrun;
    logic [7:0] rx_data;

    int checks = 0;
    int failures = 0;
    int seen_underrun = 0;
    int exp_underrun = 0;
    int seen_rx = 0;

    // Model state: bytes waiting in TX storage, and received bytes not yet strobed out.
    logic [7:0] model_q[$];
    logic [7:0] exp_rx[$];

    spi_slave_responder #(
        .IDLE_BYTE  (8'hFF),
        .TX_FIFO_AW (2)
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .spi_ss_i      (ss),
        .spi_sck_i     (sck),
        .spi_mosi_i    (mosi),
        .spi_miso_o    (miso),
        .spi_miso_oe_o (miso_oe),
        .rx_data_o     (rx_data),
        .rx_valid_o    (rx_valid),
        .tx_data_i     (tx_data),
        .tx_wr_i       (tx_wr),
        .tx_ready_o    (tx_ready),
        .tx_underrun_o (tx_underrun)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Compare process: every strobe must match the oldest byte the master completed.
    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_underrun) seen_underrun++;
            if (rx_valid) begin
                seen_rx++;
                if (exp_rx.size() == 0) check("rx_valid_unexpected", rx_valid, 1'b0);
                else check("rx_data", rx_data, exp_rx.pop_front());
            end
        end
    end

    task automatic model_load(output logic [7:0] b);
        if (model_q.size() > 0) begin
            b = model_q.pop_front();
        end else begin
            b = 8'hFF;
            exp_underrun++;
        end
    endtask

    // Called just after a falling clk edge; spends one clock.
    task automatic tx_write(input logic [7:0] d);
        check("tx_ready", tx_ready, model_q.size() < DEPTH);
        tx_data = d;
        tx_wr   = 1'b1;
        if (model_q.size() < DEPTH) model_q.push_back(d);
        tick(1);
        tx_wr = 1'b0;
    endtask

    function automatic byte_q_t mkq(input int n, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        byte_q_t q;
        q = {};
        if (n > 0) q.push_back(a);
        if (n > 1) q.push_back(b);
        if (n > 2) q.push_back(c);
        return q;
    endfunction

    // One SS frame. abort_byte/abort_rise end it early after that many rises of that byte.
    task automatic send_frame(input byte_q_t tx_bytes, input byte_q_t mid_w,
                              input int abort_byte, input int abort_rise, output byte_q_t got);
        logic [7:0] cur, out_b, m;
        bit done;
        done = 1'b0;
        got  = {};
        ss   = 1'b0;
        sck  = 1'b0;
        model_load(cur);
        tick(4);
        for (int k = 0; k < tx_bytes.size() && !done; k++) begin
            m     = tx_bytes[k];
            out_b = 8'h00;
            for (int i = 0; i < 8 && !done; i++) begin
                mosi = m[7-i];
                tick(4);
                check("miso_oe", miso_oe, 1'b1);
                check("miso_bit", miso, cur[7-i]);
                out_b[7-i] = miso;
                sck = 1'b1;
                if (i == 7) begin
                    exp_rx.push_back(m);
                    got.push_back(out_b);
                end
                if (i == 3 && k < mid_w.size()) begin
                    tx_write(mid_w[k]);
                    tick(3);
                end else begin
                    tick(4);
                end
                sck = 1'b0;
                if ((k == abort_byte && i + 1 == abort_rise) || (k == tx_bytes.size() - 1 && i == 7)) begin
                    ss   = 1'b1;
                    done = 1'b1;
                end else if (i == 7) begin
                    model_load(cur);
                end
            end
        end
        tick(3);
        check("oe_release", miso_oe, 1'b0);
        tick(6);
        check("rx_pending", exp_rx.size(), 0);
        check("underrun_count", seen_underrun, exp_underrun);
    endtask

    initial begin
        byte_q_t    got, none, mid;
        int         r0, u0, nb, nmid, ab, ar;
        none = {};

        // Reset values
        tick(3);
        check("rst_miso", miso, 1'b1);
        check("rst_oe", miso_oe, 1'b0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_tx_ready", tx_ready, 1'b1);
        check("rst_underrun", tx_underrun, 1'b0);
        rst_n = 1'b1;
        tick(4);

        // Reset mid-byte with TX storage full
        ss = 1'b0;
        tick(8);
        sck = 1'b1;
        tick(4);
        for (int w = 0; w < DEPTH; w++) tx_write(8'h90 + 8'(w));
        check("pre_rst_ready", tx_ready, model_q.size() < DEPTH);
        sck = 1'b0;
        tick(4);
        sck = 1'b1;
        tick(4);
        rst_n = 1'b0;
        ss    = 1'b1;
        sck   = 1'b0;
        tick(2);
        check("rst_mid_miso", miso, 1'b1);
        check("rst_mid_oe", miso_oe, 1'b0);
        check("rst_mid_rx_data", rx_data, 8'h00);
        check("rst_mid_rx_valid", rx_valid, 1'b0);
        check("rst_mid_tx_ready", tx_ready, 1'b1);
        check("rst_mid_underrun", tx_underrun, 1'b0);
        model_q.delete();
        exp_rx.delete();
        exp_underrun  = 0;
        seen_underrun = 0;
        seen_rx       = 0;
        rst_n = 1'b1;
        tick(4);

        // Single byte with queued TX data
        tx_write(8'hA5);
        tick(2);
        r0 = seen_rx;
        send_frame(mkq(1, 8'h3C, 8'h00, 8'h00), none, -1, 0, got);
        check("t2_miso_byte", got[0], 8'hA5);
        check("t2_rx_data", rx_data, 8'h3C);
        check("t2_rx_pulses", seen_rx - r0, 1);

        // Underrun
        u0 = seen_underrun;
        send_frame(mkq(1, 8'h00, 8'h00, 8'h00), none, -1, 0, got);
        check("t3_miso_byte", got[0], 8'hFF);
        check("t3_underrun_pulses", seen_underrun - u0, 1);
        check("t3_rx_data", rx_data, 8'h00);

        // Three bytes under one select
`ifdef SPI_SLAVE_TX_FIFO_EN
        tx_write(8'h11);
        tx_write(8'h22);
        tx_write(8'h33);
        mid = none;
`else
        tx_write(8'h11);
        mid = mkq(2, 8'h22, 8'h33, 8'h00);
`endif
        tick(2);
        r0 = seen_rx;
        send_frame(mkq(3, 8'h01, 8'h02, 8'h03), mid, -1, 0, got);
        check("t4_miso_0", got[0], 8'h11);
        check("t4_miso_1", got[1], 8'h22);
        check("t4_miso_2", got[2], 8'h33);
        check("t4_rx_pulses", seen_rx - r0, 3);
        check("t4_rx_data", rx_data, 8'h03);

        // Abort after 5 rises, then a clean frame
        r0 = seen_rx;
        send_frame(mkq(1, 8'hE7, 8'h00, 8'h00), none, 0, 5, got);
        check("t5_abort_pulses", seen_rx - r0, 0);
        send_frame(mkq(1, 8'h81, 8'h00, 8'h00), none, -1, 0, got);
        check("t5_rx_data", rx_data, 8'h81);
        check("t5_rx_pulses", seen_rx - r0, 1);

        // Overfill TX storage, then drain
        for (int w = 0; w < 5; w++) tx_write(8'h40 + 8'(w));
        check("t6_ready_full", tx_ready, 1'b0);
        mid = {};
        for (int j = 0; j < DEPTH; j++) mid.push_back(8'($urandom));
        tick(2);
        send_frame(mid, none, -1, 0, got);
        for (int j = 0; j < DEPTH; j++) check("t6_drain", got[j], 8'h40 + 8'(j));
        check("t6_ready_after", tx_ready, 1'b1);

        // Randomized frames
        for (int it = 0; it < 40; it++) begin
            for (int w = $urandom_range(0, 5); w > 0; w--) tx_write(8'($urandom));
            tick(2);
            nb   = $urandom_range(1, 3);
            nmid = $urandom_range(0, nb);
            ab   = -1;
            ar   = 0;
            if ($urandom_range(0, 3) == 0) begin
                ab = $urandom_range(0, nb - 1);
                ar = $urandom_range(1, 7);
            end
            got = {};
            for (int j = 0; j < nb; j++) got.push_back(8'($urandom));
            mid = {};
            for (int j = 0; j < nmid; j++) mid.push_back(8'($urandom));
            send_frame(got, mid, ab, ar, got);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
